// File: rtl/box_renderer.sv
// Checkerboard background with a bouncing, colour-changing box, rendered as
// registered RGB565 two cycles behind the timing generator, syncs delay-matched.
module box_renderer #(
    parameter int          SCREEN_WIDTH  = 800,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          BOX_SIZE      = 64,
    parameter int          STEP          = 2,
    parameter logic [15:0] BG_A          = 16'h0010,
    parameter logic [15:0] BG_B          = 16'h0000
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       DE,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic       FRAME_END,
    output logic [4:0] LCD_R,
    output logic [5:0] LCD_G,
    output logic [4:0] LCD_B,
    output logic       LCD_DE,
    output logic       LCD_HSYNC,
    output logic       LCD_VSYNC
);

    localparam logic [10:0] MAX_X  = 11'(SCREEN_WIDTH - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(SCREEN_HEIGHT - BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);
    localparam logic [9:0]  STEP10 = 10'(STEP);

    logic [9:0]  r_box_x, r_box_y;
    logic        r_dir_x, r_dir_y;
    logic [1:0]  r_col_idx;

    logic [10:0] w_x_inc, w_y_inc;
    logic [9:0]  w_x_dec, w_y_dec;
    logic [9:0]  w_next_x, w_next_y;
    logic        w_next_dir_x, w_next_dir_y;
    logic        w_bounce_x, w_bounce_y;

    assign w_x_inc = {1'b0, r_box_x} + STEP_W;
    assign w_y_inc = {1'b0, r_box_y} + STEP_W;
    // Only used when the position is known to exceed STEP, so it cannot wrap.
    assign w_x_dec = r_box_x - STEP10;
    assign w_y_dec = r_box_y - STEP10;

    always_comb begin
        w_next_x     = r_box_x;
        w_next_dir_x = r_dir_x;
        w_bounce_x   = 1'b0;
        if (!r_dir_x) begin
            if (w_x_inc >= MAX_X) begin
                w_next_x     = MAX_X[9:0];
                w_next_dir_x = 1'b1;
                w_bounce_x   = 1'b1;
            end else begin
                w_next_x = w_x_inc[9:0];
            end
        end else if ({1'b0, r_box_x} <= STEP_W) begin
            w_next_x     = '0;
            w_next_dir_x = 1'b0;
            w_bounce_x   = 1'b1;
        end else begin
            w_next_x = w_x_dec;
        end
    end

    always_comb begin
        w_next_y     = r_box_y;
        w_next_dir_y = r_dir_y;
        w_bounce_y   = 1'b0;
        if (!r_dir_y) begin
            if (w_y_inc >= MAX_Y) begin
                w_next_y     = MAX_Y[9:0];
                w_next_dir_y = 1'b1;
                w_bounce_y   = 1'b1;
            end else begin
                w_next_y = w_y_inc[9:0];
            end
        end else if ({1'b0, r_box_y} <= STEP_W) begin
            w_next_y     = '0;
            w_next_dir_y = 1'b0;
            w_bounce_y   = 1'b1;
        end else begin
            w_next_y = w_y_dec;
        end
    end

    // A corner hit bounces both axes on one frame but advances the colour once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_box_x   <= '0;
            r_box_y   <= '0;
            r_dir_x   <= 1'b0;
            r_dir_y   <= 1'b0;
            r_col_idx <= '0;
        end else if (FRAME_END) begin
            r_box_x <= w_next_x;
            r_box_y <= w_next_y;
            r_dir_x <= w_next_dir_x;
            r_dir_y <= w_next_dir_y;
            if (w_bounce_x || w_bounce_y) r_col_idx <= r_col_idx + 2'd1;
        end
    end

    logic [10:0] w_x11, w_y11;
    logic        w_inside;

    assign w_x11    = {1'b0, X};
    assign w_y11    = {1'b0, Y};
    assign w_inside = (w_x11 >= {1'b0, r_box_x}) && (w_x11 < ({1'b0, r_box_x} + SIZE_W)) &&
                      (w_y11 >= {1'b0, r_box_y}) && (w_y11 < ({1'b0, r_box_y} + SIZE_W));

    logic       r_s1_in, r_s1_tile, r_s1_de, r_s1_hs, r_s1_vs;
    logic [1:0] r_s1_col;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_s1_in   <= 1'b0;
            r_s1_tile <= 1'b0;
            r_s1_de   <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_col  <= '0;
        end else begin
            r_s1_in   <= w_inside;
            r_s1_tile <= X[5] ^ Y[5];
            r_s1_de   <= DE;
            r_s1_hs   <= HSYNC;
            r_s1_vs   <= VSYNC;
            r_s1_col  <= r_col_idx;
        end
    end

    logic [15:0] w_pix;

    always_comb begin
        w_pix = 16'h0000;
        if (r_s1_de) begin
            if (r_s1_in) begin
                case (r_s1_col)
                    2'd0:    w_pix = 16'hF800;
                    2'd1:    w_pix = 16'h07E0;
                    2'd2:    w_pix = 16'hFFE0;
                    default: w_pix = 16'hFFFF;
                endcase
            end else begin
                w_pix = r_s1_tile ? BG_B : BG_A;
            end
        end
    end

    logic [15:0] r_rgb;
    logic        r_s2_de, r_s2_hs, r_s2_vs;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rgb   <= '0;
            r_s2_de <= 1'b0;
            r_s2_hs <= 1'b1;
            r_s2_vs <= 1'b1;
        end else begin
            r_rgb   <= w_pix;
            r_s2_de <= r_s1_de;
            r_s2_hs <= r_s1_hs;
            r_s2_vs <= r_s1_vs;
        end
    end

    assign LCD_R     = r_rgb[15:11];
    assign LCD_G     = r_rgb[10:5];
    assign LCD_B     = r_rgb[4:0];
    assign LCD_DE    = r_s2_de;
    assign LCD_HSYNC = r_s2_hs;
    assign LCD_VSYNC = r_s2_vs;

endmodule
